seg_display: RTL
================

SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 SHALL have port: clk_slow  input  1  scan/logic clock.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-low; clock clk_slow.
REQ-003 SHALL have port: data_in  input  32  unsigned value to display.
REQ-004 SHALL have port: load  input  1  one-cycle pulse; capture data_in.
REQ-005 SHALL have port: dec_mode  input  1  sampled with load; 1 = decimal, 0 = hex.
REQ-006 SHALL have port: busy  output  1  decimal conversion in progress.
REQ-007 SHALL have port: seg  output  [1:0][7:0]  segment lines per group; bit0=a..bit6=g, bit7=dp; active-high.
REQ-008 SHALL have port: seg_sel  output  [1:0][3:0]  digit enables per group; one-hot, active-high.

Function
REQ-009 SHALL display 8 digits: group 0 = digits 0-3 (least significant), group 1 = digits 4-7.
REQ-010 SHALL run a 2-bit scan index k, incrementing every clk_slow cycle and wrapping 3->0; seg_sel[g] = 1<<k, seg[g] = pattern of digit 4g+k.
REQ-011 SHALL register seg and seg_sel, so the pattern for index k appears one cycle after k is reached.
REQ-012 SHALL encode hex digits 0-F as 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; blank = 00; dash = 40; dp always 0.
REQ-013 SHALL blank leading zeros: every digit above the most significant non-zero digit is blank, and digit 0 is always shown.
REQ-014 Hex load (dec_mode=0): displayed value SHALL update on the cycle after load, with busy staying 0.
REQ-015 Decimal load: SHALL assert busy on the cycle after load, run a 32-iteration shift-and-add-3 conversion (one iteration per cycle), then drop busy and update the display in the same cycle.
REQ-016 The old display SHALL persist unchanged while busy=1; the update is atomic.
REQ-017 Decimal value > 99_999_999 SHALL display dash on all 8 digits.
REQ-018 A load while busy=1 SHALL abort the running conversion and start a new one (or a hex update) for the new data_in/dec_mode; no stale result may ever be shown.
REQ-019 load=0 SHALL leave the captured value and mode unchanged indefinitely.

Reset
REQ-020 With rst=0 at a clk_slow edge: scan index=0, stored value=0, mode=hex, busy=0, conversion aborted, seg=all 00, seg_sel=all 0000.
REQ-021 The first cycle after reset release SHALL drive index 0; the display then shows "0" on digit 0 with all others blank.
REQ-022 Reset SHALL dominate a simultaneous load.

Configuration
REQ-023 Macro SEG_DISPLAY_DEC_EN: when defined, decimal mode (REQ-015..017) is compiled in.
REQ-024 Without SEG_DISPLAY_DEC_EN: dec_mode is ignored, every load behaves as a hex load, busy is tied 0, and no conversion logic is present.

Structure
REQ-025 Package seg_pkg SHALL hold: the segment-pattern constants (0-F, blank, dash), NUM_DIGITS=8, DIGITS_PER_GROUP=4, and the scan-index width.
REQ-026 Sub-module bin2bcd (sequential double-dabble: start, abort, done, 32-bit in, 8 BCD digits + overflow out) SHALL be instantiated only under SEG_DISPLAY_DEC_EN.

Verification
REQ-027 Reset, then 8 cycles -> seg_sel[0] cycles 0001,0010,0100,1000,0001...; seg[0]=3F only when seg_sel[0]=0001 (00 otherwise); seg[1]=00 throughout.
REQ-028 Hex load 32'hDEADBEEF -> digits 7..0 = 5E,79,77,5E,7C,79,79,71; busy stays 0.
REQ-029 Hex load 32'h0000_0A05 -> digit2=77, digit1=3F, digit0=6D, digits 3-7 blank.
REQ-030 (DEC_EN) Decimal load 12345 -> busy high for 32 cycles; the old display is held throughout; then digits 4..0 = 06,5B,4F,66,6D, upper blank.
REQ-031 (DEC_EN) Decimal load 100_000_000 -> all digits 40; then a hex load of 5 issued mid-conversion of a prior decimal load -> busy drops and digit 0 = 6D, with no dash ever shown.
REQ-032 rst asserted mid-conversion -> busy=0 next cycle and the display returns to the reset state.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seg_display slice: segment patterns, digit counts
// and scan-index width.
package seg_pkg;

   localparam int NUM_DIGITS       = 8;
   localparam int DIGITS_PER_GROUP = 4;
   localparam int IDX_W            = 2;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'h40;

   // Entry [n] is the pattern for hex digit n (bit0=a .. bit6=g, dp=0).
   localparam logic [15:0][7:0] SEG_HEX = {
      8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
      8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

endpackage

// File: rtl/seg_display_bin2bcd.sv
// Sequential double-dabble: 32 shift-and-add-3 iterations, one per clock.
// Keeps the low 8 BCD digits and flags inputs above 99_999_999.
module bin2bcd
   import seg_pkg::*;
(
   input  logic                       clk_slow,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic                       i_abort,
   input  logic [31:0]                i_bin,
   output logic                       o_done,
   output logic [NUM_DIGITS-1:0][3:0] o_bcd,
   output logic                       o_ovf
);

   logic [31:0]                r_bin;
   logic [NUM_DIGITS-1:0][3:0] r_bcd;
   logic [4:0]                 r_cnt;
   logic                       r_run;
   logic                       r_ovf;
   logic [NUM_DIGITS-1:0][3:0] w_adj;
   logic [31:0]                w_adj_flat;
   logic [31:0]                w_bcd_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
         assign w_adj[gi] = (r_bcd[gi] >= 4'd5) ? r_bcd[gi] + 4'd3 : r_bcd[gi];
      end
   endgenerate

   // Digits beyond the eighth shift out of the top; the low digits stay exact.
   assign w_adj_flat = w_adj;
   assign w_bcd_next = {w_adj_flat[30:0], r_bin[31]};

   // Result is presented combinationally during the last iteration so the
   // caller can commit it on the same edge that ends the conversion.
   assign o_done = r_run && (r_cnt == 5'd31);
   assign o_bcd  = w_bcd_next;
   assign o_ovf  = r_ovf;

   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
         r_ovf <= 1'b0;
      end else if (i_start) begin
         r_bin <= i_bin;
         r_bcd <= '0;
         r_cnt <= '0;
         r_run <= 1'b1;
         r_ovf <= (i_bin > 32'd99_999_999);
      end else if (i_abort) begin
         r_run <= 1'b0;
      end else if (r_run) begin
         r_bin <= r_bin << 1;
         r_bcd <= w_bcd_next;
         r_cnt <= r_cnt + 5'd1;
         if (r_cnt == 5'd31)
            r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/seg_display.sv
// Eight-digit, two-group multiplexed 7-segment driver (hex, optional decimal).
// Decimal mode is compiled in only when SEG_DISPLAY_DEC_EN is defined.
module seg_display
   import seg_pkg::*;
(
   input  logic                             clk_slow,
   input  logic                             rst,
   input  logic [31:0]                      data_in,
   input  logic                             load,
   input  logic                             dec_mode,
   output logic                             busy,
   output logic [1:0][7:0]                  seg,
   output logic [1:0][DIGITS_PER_GROUP-1:0] seg_sel
);

   logic [IDX_W-1:0]                  r_idx;
   logic [NUM_DIGITS-1:0][3:0]        r_digits;
   logic                              r_dash;
   logic [NUM_DIGITS-1:0][7:0]        w_pat;
   logic [1:0][7:0]                   w_seg_next;
   logic [1:0][DIGITS_PER_GROUP-1:0]  w_sel_next;
   logic                              w_hex_load;

`ifdef SEG_DISPLAY_DEC_EN
   logic                       w_dec_load;
   logic                       w_done;
   logic                       w_ovf;
   logic [NUM_DIGITS-1:0][3:0] w_bcd;
   logic                       r_busy;

   assign w_hex_load = load && !dec_mode;
   assign w_dec_load = load && dec_mode;
   assign busy       = r_busy;

   bin2bcd u_bin2bcd (
      .clk_slow (clk_slow),
      .rst      (rst),
      .i_start  (w_dec_load),
      .i_abort  (w_hex_load),
      .i_bin    (data_in),
      .o_done   (w_done),
      .o_bcd    (w_bcd),
      .o_ovf    (w_ovf)
   );

   always_ff @(posedge clk_slow) begin
      if (!rst)
         r_busy <= 1'b0;
      else if (load)
         r_busy <= dec_mode;
      else if (w_done)
         r_busy <= 1'b0;
   end
`else
   logic w_unused;

   assign w_hex_load = load;
   assign busy       = 1'b0;
   assign w_unused   = dec_mode;
`endif

   // Displayed digits change only here, so a conversion result lands atomically.
   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         r_digits <= '0;
         r_dash   <= 1'b0;
      end else if (w_hex_load) begin
         r_digits <= data_in;
         r_dash   <= 1'b0;
      end
`ifdef SEG_DISPLAY_DEC_EN
      else if (w_done && !w_dec_load) begin
         r_digits <= w_bcd;
         r_dash   <= w_ovf;
      end
`endif
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic w_show;
         assign w_show    = (gi == 0) || (|r_digits[NUM_DIGITS-1:gi]);
         assign w_pat[gi] = r_dash ? SEG_DASH :
                            w_show ? SEG_HEX[r_digits[gi]] : SEG_BLANK;
      end

      for (gi = 0; gi < 2; gi++) begin : g_group
         localparam logic GRP = (gi != 0);
         assign w_seg_next[gi] = w_pat[{GRP, r_idx}];
         assign w_sel_next[gi] = 4'b0001 << r_idx;
      end
   endgenerate

   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         r_idx   <= '0;
         seg     <= '0;
         seg_sel <= '0;
      end else begin
         r_idx   <= r_idx + IDX_W'(1);
         seg     <= w_seg_next;
         seg_sel <= w_sel_next;
      end
   end

endmodule
